// File: rtl/bus_control_logic.sv
`default_nettype none
// ============================================================================
//  Module      : bus_control_logic
//  Description : CPU-side bus interface of the 8259 PIC. It samples the
//                asynchronous CS#/RD#/WR#/A0/D pins and latches write data
//                onto internal_data_bus. On each WR# rising edge that ends a
//                captured write, it issues one set of one-clock ICW/OCW write
//                strobes. The strobe is decoded from the latched A0 and data.
//                Ordering of ICW2/3/4 against OCW1 is resolved downstream
//                in the controller.
//
//  Optional feature macro:
//    BUS_INPUT_SYNC_EN  defined   : 2-flop synchronizer on all bus pins
//                                   before the edge logic (+1 clk latency)
//    BUS_INPUT_SYNC_EN  undefined : single sample register
//
//  Ports:
//    clock                          in   system clock, rising edge
//    reset_n                        in   asynchronous active-low reset
//    chip_select_n                  in   CS#, async, active low
//    read_enable_n                  in   RD#, async, active low
//    write_enable_n                 in   WR#, async, active low
//    address                        in   A0
//    data_bus_in                    in   CPU write data
//    internal_data_bus              out  latched write data
//    write_initial_command_word_1   out  ICW1 strobe
//    write_initial_command_word_2_4 out  A0=1 write strobe
//    write_operation_control_word_1 out  A0=1 write strobe (paired)
//    write_operation_control_word_2 out  OCW2 strobe
//    write_operation_control_word_3 out  OCW3 strobe
//    read                           out  CS# and RD# sampled low, WR# high
//
//  Revision    : 1.0  initial release
// ============================================================================
module bus_control_logic #(
    parameter int              DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  chip_select_n,
    input  logic                  read_enable_n,
    input  logic                  write_enable_n,
    input  logic                  address,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  write_initial_command_word_1,
    output logic                  write_initial_command_word_2_4,
    output logic                  write_operation_control_word_1,
    output logic                  write_operation_control_word_2,
    output logic                  write_operation_control_word_3,
    output logic                  read
);

    // Sampled copies of the bus pins as seen by the edge/capture logic.
    logic                  r_cs_s;
    logic                  r_rd_s;
    logic                  r_wr_s;
    logic                  r_a0_s;
    logic [DATA_WIDTH-1:0] r_d_s;

`ifdef BUS_INPUT_SYNC_EN
    // First synchronizer stage. Data and A0 pass through the same number of
    // stages as WR# so that the captured value lines up with the strobe.
    logic                  r_cs_m;
    logic                  r_rd_m;
    logic                  r_wr_m;
    logic                  r_a0_m;
    logic [DATA_WIDTH-1:0] r_d_m;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_m <= 1'b1;
            r_rd_m <= 1'b1;
            r_wr_m <= 1'b1;
            r_a0_m <= 1'b0;
            r_d_m  <= '0;
            r_cs_s <= 1'b1;
            r_rd_s <= 1'b1;
            r_wr_s <= 1'b1;
            r_a0_s <= 1'b0;
            r_d_s  <= '0;
        end else begin
            r_cs_m <= chip_select_n;
            r_rd_m <= read_enable_n;
            r_wr_m <= write_enable_n;
            r_a0_m <= address;
            r_d_m  <= data_bus_in;
            r_cs_s <= r_cs_m;
            r_rd_s <= r_rd_m;
            r_wr_s <= r_wr_m;
            r_a0_s <= r_a0_m;
            r_d_s  <= r_d_m;
        end
    end
`else
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cs_s <= 1'b1;
            r_rd_s <= 1'b1;
            r_wr_s <= 1'b1;
            r_a0_s <= 1'b0;
            r_d_s  <= '0;
        end else begin
            r_cs_s <= chip_select_n;
            r_rd_s <= read_enable_n;
            r_wr_s <= write_enable_n;
            r_a0_s <= address;
            r_d_s  <= data_bus_in;
        end
    end
`endif

    logic                  r_wr_prev;
    logic                  r_armed;
    logic                  r_a0_q;
    logic [DATA_WIDTH-1:0] r_bus;
    logic                  r_icw1;
    logic                  r_icw24;
    logic                  r_ocw1;
    logic                  r_ocw2;
    logic                  r_ocw3;

    logic w_capture;
    logic w_wr_rise;
    logic w_fire;

    assign w_capture = ~r_cs_s & ~r_wr_s;
    assign w_wr_rise = ~r_wr_prev & r_wr_s;
    // Armed is set while a chip-selected write is in progress, so a CS#
    // release before WR# rises still produces the strobe.
    assign w_fire    = w_wr_rise & r_armed;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_prev <= 1'b1;
            r_armed   <= 1'b0;
            r_a0_q    <= 1'b0;
            r_bus     <= RESET_DATA;
            r_icw1    <= 1'b0;
            r_icw24   <= 1'b0;
            r_ocw1    <= 1'b0;
            r_ocw2    <= 1'b0;
            r_ocw3    <= 1'b0;
        end else begin
            r_wr_prev <= r_wr_s;

            // Capture and fire are exclusive: capture needs WR# low, the
            // rising edge needs WR# high.
            if (w_capture) begin
                r_bus   <= r_d_s;
                r_a0_q  <= r_a0_s;
                r_armed <= 1'b1;
            end else if (w_fire) begin
                r_armed <= 1'b0;
            end

            r_icw1  <= w_fire & ~r_a0_q &  r_bus[4];
            r_icw24 <= w_fire &  r_a0_q;
            r_ocw1  <= w_fire &  r_a0_q;
            r_ocw2  <= w_fire & ~r_a0_q & ~r_bus[4] & ~r_bus[3];
            r_ocw3  <= w_fire & ~r_a0_q & ~r_bus[4] &  r_bus[3];
        end
    end

    assign internal_data_bus              = r_bus;
    assign write_initial_command_word_1   = r_icw1;
    assign write_initial_command_word_2_4 = r_icw24;
    assign write_operation_control_word_1 = r_ocw1;
    assign write_operation_control_word_2 = r_ocw2;
    assign write_operation_control_word_3 = r_ocw3;

    // A write in progress masks a simultaneous read.
    assign read = ~r_cs_s & ~r_rd_s & r_wr_s;

endmodule
`default_nettype wire

// File: tb/tb_bus_control_logic.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_control_logic
//  Description : Self-checking bench for bus_control_logic. Stimulus pushes
//                the expected strobe set, bus value and cycle into a queue;
//                a monitor pops and compares whenever any strobe is high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_control_logic;

`ifdef BUS_INPUT_SYNC_EN
    localparam int c_LAT = 2;
`else
    localparam int c_LAT = 1;
`endif

    // Strobe vector order: {icw1, icw2_4, ocw1, ocw2, ocw3}
    localparam logic [4:0] c_S_ICW1 = 5'b10000;
    localparam logic [4:0] c_S_A01  = 5'b01100;
    localparam logic [4:0] c_S_OCW2 = 5'b00010;
    localparam logic [4:0] c_S_OCW3 = 5'b00001;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       chip_select_n = 1'b1;
    logic       read_enable_n = 1'b1;
    logic       write_enable_n = 1'b1;
    logic       address = 1'b0;
    logic [7:0] data_bus_in = 8'h00;
    logic [7:0] internal_data_bus;
    logic       icw1, icw24, ocw1, ocw2, ocw3, read;

    bus_control_logic #(.DATA_WIDTH(8), .RESET_DATA(8'h00)) dut (
        .clock                          (clock),
        .reset_n                        (reset_n),
        .chip_select_n                  (chip_select_n),
        .read_enable_n                  (read_enable_n),
        .write_enable_n                 (write_enable_n),
        .address                        (address),
        .data_bus_in                    (data_bus_in),
        .internal_data_bus              (internal_data_bus),
        .write_initial_command_word_1   (icw1),
        .write_initial_command_word_2_4 (icw24),
        .write_operation_control_word_1 (ocw1),
        .write_operation_control_word_2 (ocw2),
        .write_operation_control_word_3 (ocw3),
        .read                           (read)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [4:0] stb;
        logic [7:0] bus;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: any strobe activity must match the head of the scoreboard.
    logic [4:0] w_stb;
    logic       r_prev_any = 1'b0;
    assign w_stb = {icw1, icw24, ocw1, ocw2, ocw3};

    always @(negedge clock) begin
        if (w_stb != 5'b0) begin
            if (r_prev_any) begin
                tests++;
                errors++;
                $display("FAIL strobe_consecutive: got 0x%0h expected 0x0 (cycle %0d)", w_stb, cyc);
            end
            if (sbq.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_strobe: got 0x%0h expected none (cycle %0d)", w_stb, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("strobe_set", 32'(w_stb), 32'(e.stb));
                check("strobe_bus", 32'(internal_data_bus), 32'(e.bus));
                check("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        r_prev_any <= (w_stb != 5'b0);
    end

    // Called on the negedge where WR# is driven high.
    task automatic push_exp(input logic [4:0] stb, input logic [7:0] bus);
        exp_t e;
        e.cyc = cyc + 1 + c_LAT;
        e.stb = stb;
        e.bus = bus;
        sbq.push_back(e);
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d, input logic [4:0] stb);
        @(negedge clock);
        chip_select_n  = 1'b0;
        address        = a0;
        data_bus_in    = d;
        write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
        write_enable_n = 1'b1;
        push_exp(stb, d);
        @(negedge clock);
        chip_select_n = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        // Reset with random pins
        chip_select_n  = 1'($urandom);
        read_enable_n  = 1'($urandom);
        write_enable_n = 1'($urandom);
        address        = 1'($urandom);
        data_bus_in    = 8'($urandom);
        repeat (3) @(negedge clock);
        check("reset_strobes", 32'(w_stb), 32'h0);
        check("reset_read", 32'(read), 32'h0);
        check("reset_bus", 32'(internal_data_bus), 32'h00);
        chip_select_n  = 1'b1;
        read_enable_n  = 1'b1;
        write_enable_n = 1'b1;
        address        = 1'b0;
        data_bus_in    = 8'h00;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);

        // Decoded writes, back-to-back OCW2/OCW3
        do_write(1'b0, 8'h1B, c_S_ICW1);
        check("bus_after_icw1", 32'(internal_data_bus), 32'h1B);
        do_write(1'b1, 8'h07, c_S_A01);
        check("bus_after_icw2", 32'(internal_data_bus), 32'h07);
        do_write(1'b0, 8'h20, c_S_OCW2);
        do_write(1'b0, 8'h0B, c_S_OCW3);

        // CS# released one clock before WR# rises
        @(negedge clock);
        chip_select_n  = 1'b0;
        address        = 1'b0;
        data_bus_in    = 8'h3C;
        write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
        chip_select_n = 1'b1;
        @(negedge clock);
        write_enable_n = 1'b1;
        push_exp(c_S_ICW1, 8'h3C);
        repeat (4) @(negedge clock);

        // WR# pulse without CS#: no strobe, bus held
        address        = 1'b1;
        data_bus_in    = 8'hA5;
        write_enable_n = 1'b0;
        repeat (3) @(negedge clock);
        write_enable_n = 1'b1;
        repeat (5) @(negedge clock);
        check("bus_no_cs", 32'(internal_data_bus), 32'h3C);

        // Read level, then RD#+WR# low (write wins)
        chip_select_n = 1'b0;
        read_enable_n = 1'b0;
        repeat (c_LAT + 1) @(negedge clock);
        check("read_active", 32'(read), 32'h1);
        address        = 1'b0;
        data_bus_in    = 8'h0B;
        write_enable_n = 1'b0;
        repeat (c_LAT + 1) @(negedge clock);
        check("read_masked_by_write", 32'(read), 32'h0);
        read_enable_n  = 1'b1;
        write_enable_n = 1'b1;
        push_exp(c_S_OCW3, 8'h0B);
        @(negedge clock);
        chip_select_n = 1'b1;
        repeat (4) @(negedge clock);
        check("read_idle", 32'(read), 32'h0);

        // Reset mid-write, released with WR# still low: one strobe
        chip_select_n  = 1'b0;
        address        = 1'b0;
        data_bus_in    = 8'h13;
        write_enable_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("bus_in_reset", 32'(internal_data_bus), 32'h00);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        write_enable_n = 1'b1;
        push_exp(c_S_ICW1, 8'h13);
        @(negedge clock);
        chip_select_n = 1'b1;
        repeat (4) @(negedge clock);

        // WR# low only inside reset: no strobe
        reset_n = 1'b0;
        @(negedge clock);
        chip_select_n  = 1'b0;
        address        = 1'b1;
        data_bus_in    = 8'h55;
        write_enable_n = 1'b0;
        repeat (2) @(negedge clock);
        write_enable_n = 1'b1;
        chip_select_n  = 1'b1;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        check("bus_after_reset_only_write", 32'(internal_data_bus), 32'h00);

        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
`default_nettype wire
